// File: rtl/cg_sched.sv
// rtl/cg_sched.sv - clock-gating scheduler: per-bank idle gating with round-robin serialised wake-up
module cg_sched #(
  parameter int N_DOM    = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_DOM-1:0]  req,
  input  logic [IDLE_W-1:0] idle_thr,
  input  logic              force_on,
  output logic [N_DOM-1:0]  cg_en,
  output logic [N_DOM-1:0]  rdy,
  output logic              wake_busy
);

  localparam int PTR_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam int WC_W  = (WAKE_CYC > 0) ? $clog2(WAKE_CYC + 1) : 1;

  typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON} state_t;

  state_t            st   [N_DOM];
  logic [WC_W-1:0]   wcnt [N_DOM];
  logic [IDLE_W-1:0] icnt [N_DOM];
  logic [PTR_W-1:0]  ptr;

  logic [N_DOM-1:0]  cand;
  logic [N_DOM-1:0]  in_wake;
  logic [N_DOM-1:0]  wake_done;
  logic [N_DOM-1:0]  idle_hold;
  logic [N_DOM-1:0]  idle_hit;
  logic              gnt_any;
  logic [PTR_W-1:0]  gnt_idx;
  logic              wake_busy_nx;

  always_comb begin
    for (int i = 0; i < N_DOM; i++) begin
      cand[i]      = (st[i] == S_OFF) && req[i];
      in_wake[i]   = (st[i] == S_WAKE);
      wake_done[i] = in_wake[i] && (wcnt[i] == WC_W'(WAKE_CYC - 1));
      idle_hold[i] = req[i] || force_on || (idle_thr == '0);
      // One extra bit so the +1 never wraps when the counter is saturated.
      idle_hit[i]  = ({1'b0, icnt[i]} + {{IDLE_W{1'b0}}, 1'b1}) >= {1'b0, idle_thr};
    end
  end

  // Scan from the highest offset down so the candidate nearest ptr wins last.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] sel;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    sel     = '0;
    for (int k = N_DOM - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_DOM) idx = idx - N_DOM;
      sel = PTR_W'(idx);
      if (cand[sel]) begin
        gnt_any = 1'b1;
        gnt_idx = sel;
      end
    end
    if (wake_busy) gnt_any = 1'b0;
  end

  assign wake_busy_nx = gnt_any || |(in_wake & ~wake_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_DOM; i++) begin
        st[i]   <= S_OFF;
        wcnt[i] <= '0;
        icnt[i] <= '0;
      end
      cg_en     <= '0;
      rdy       <= '0;
      wake_busy <= 1'b0;
      ptr       <= '0;
    end else begin
      wake_busy <= wake_busy_nx;
      if (gnt_any) begin
        ptr <= (gnt_idx == PTR_W'(N_DOM - 1)) ? '0 : gnt_idx + 1'b1;
      end
      for (int i = 0; i < N_DOM; i++) begin
        case (st[i])
          S_OFF: begin
            if (gnt_any && (gnt_idx == PTR_W'(i))) begin
              st[i]    <= S_WAKE;
              wcnt[i]  <= '0;
              cg_en[i] <= 1'b1;
            end else begin
              cg_en[i] <= force_on;
            end
            rdy[i] <= 1'b0;
          end
          S_WAKE: begin
            cg_en[i] <= 1'b1;
            if (wake_done[i]) begin
              st[i]   <= S_ON;
              rdy[i]  <= 1'b1;
              wcnt[i] <= '0;
              icnt[i] <= '0;
            end else begin
              wcnt[i] <= wcnt[i] + 1'b1;
            end
          end
          S_ON: begin
            if (idle_hold[i]) begin
              icnt[i] <= '0;
            end else if (idle_hit[i]) begin
              st[i]    <= S_OFF;
              cg_en[i] <= 1'b0;
              rdy[i]   <= 1'b0;
              icnt[i]  <= '0;
            end else if (icnt[i] != '1) begin
              icnt[i] <= icnt[i] + 1'b1;
            end
          end
          default: begin
            st[i]    <= S_OFF;
            cg_en[i] <= 1'b0;
            rdy[i]   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cg_sched.sv
// tb/tb_cg_sched.sv - self-checking bench for cg_sched: directed scenarios plus random traffic vs a reference model
module tb_cg_sched;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [IW-1:0] idle_thr;
  logic          force_on;
  logic [N-1:0]  cg_en;
  logic [N-1:0]  rdy;
  logic          wake_busy;

  cg_sched #(.N_DOM(N), .IDLE_W(IW), .WAKE_CYC(WC)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .idle_thr (idle_thr),
    .force_on (force_on),
    .cg_en    (cg_en),
    .rdy      (rdy),
    .wake_busy(wake_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0=off, 1=waking, 2=running; wc counts cycles spent waking.
  int       m_mode [N];
  int       m_wc   [N];
  int       m_ic   [N];
  int       m_ptr;
  bit       m_wb;
  logic [N-1:0] m_en;
  logic [N-1:0] m_rdy;
  int       rise   [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int g;
    g = -1;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_mode[i] = 0; m_wc[i] = 0; m_ic[i] = 0;
      end
      m_ptr = 0; m_wb = 0; m_en = '0; m_rdy = '0;
      return;
    end
    if (!m_wb) begin
      for (int k = 0; k < N; k++) begin
        int b;
        b = (m_ptr + k) % N;
        if (g < 0 && m_mode[b] == 0 && req[b]) g = b;
      end
    end
    if (g >= 0) m_ptr = (g + 1) % N;
    for (int i = 0; i < N; i++) begin
      case (m_mode[i])
        0: if (i == g) begin m_mode[i] = 1; m_wc[i] = 0; end
        1: begin
          m_wc[i]++;
          if (m_wc[i] == WC) begin m_mode[i] = 2; m_ic[i] = 0; end
        end
        default: begin
          if (req[i] || force_on || idle_thr == 0) m_ic[i] = 0;
          else if (m_ic[i] + 1 >= int'(idle_thr)) m_mode[i] = 0;
          else if (m_ic[i] < (1 << IW) - 1) m_ic[i]++;
        end
      endcase
    end
    m_wb = 0;
    for (int i = 0; i < N; i++) begin
      m_en[i]  = (m_mode[i] != 0) || force_on;
      m_rdy[i] = (m_mode[i] == 2);
      if (m_mode[i] == 1) m_wb = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_cg_en", 32'(cg_en), 32'(m_en));
    check("model_rdy", 32'(rdy), 32'(m_rdy));
    check("model_wake_busy", 32'(wake_busy), 32'(m_wb));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic watch_rise(input int cycles);
    for (int i = 0; i < N; i++) rise[i] = -1;
    for (int k = 1; k <= cycles; k++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (cg_en[i] && rise[i] < 0) rise[i] = k;
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; idle_thr = '0; force_on = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_cg_en", 32'(cg_en), 32'h0);
    check("reset_rdy", 32'(rdy), 32'h0);
    check("reset_wake_busy", 32'(wake_busy), 32'h0);

    // First-wake latency
    req = 4'b0001;
    tick();
    check("lat_cg_en", 32'(cg_en), 32'h1);
    check("lat_rdy_early", 32'(rdy), 32'h0);
    tick();
    check("lat_rdy_mid", 32'(rdy), 32'h0);
    tick();
    check("lat_rdy", 32'(rdy), 32'h1);

    // Idle timeout with threshold 3, then a req pulse restarting the count
    idle_thr = 8'd3;
    req = 4'b0000;
    tick(); tick();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick(); tick();
    check("idle_before_thr", 32'(rdy), 32'h1);
    tick();
    check("idle_gated_rdy", 32'(rdy), 32'h0);
    check("idle_gated_en", 32'(cg_en), 32'h0);

    // Round-robin order from ptr=0
    idle_thr = 8'd0;
    do_reset();
    req = 4'b1111;
    watch_rise(16);
    for (int i = 0; i < N; i++) check($sformatf("rr_start_%0d", i), 32'(rise[i]), 32'(1 + 3 * i));
    req = 4'b0000; idle_thr = 8'd1;
    tick(); tick();
    check("rr_all_gated", 32'(cg_en), 32'h0);
    idle_thr = 8'd0; req = 4'b0100;
    tick(); tick(); tick(); tick();
    check("rr_bank2_on", 32'(rdy), 32'h4);
    req = 4'b0000; idle_thr = 8'd1;
    tick(); tick();
    idle_thr = 8'd0; req = 4'b1011;
    watch_rise(12);
    check("rr2_bank3", 32'(rise[3]), 32'd1);
    check("rr2_bank0", 32'(rise[0]), 32'd4);
    check("rr2_bank1", 32'(rise[1]), 32'd7);

    // force_on: OFF banks enabled but not ready; ON bank never gates
    do_reset();
    req = 4'b0000; force_on = 1'b1;
    tick();
    check("force_off_en", 32'(cg_en), 32'hf);
    check("force_off_rdy", 32'(rdy), 32'h0);
    req = 4'b0001;
    tick(); tick(); tick();
    req = 4'b0000; idle_thr = 8'd3;
    for (int k = 0; k < 50; k++) tick();
    check("force_hold_rdy", 32'(rdy), 32'h1);
    force_on = 1'b0;
    tick(); tick();
    check("force_drop_rdy", 32'(rdy), 32'h1);
    tick();
    check("force_drop_gated", 32'(rdy), 32'h0);

    // idle_thr=0 keeps bank on; then threshold 5
    idle_thr = 8'd0; req = 4'b0001;
    tick(); tick(); tick();
    req = 4'b0000;
    for (int k = 0; k < 300; k++) tick();
    check("thr0_stays_on", 32'(rdy), 32'h1);
    idle_thr = 8'd5;
    for (int k = 0; k < 4; k++) tick();
    check("thr5_not_yet", 32'(rdy), 32'h1);
    tick();
    check("thr5_gated", 32'(rdy), 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int j;
        j = $urandom_range(0, N - 1);
        req[j] = ~req[j];
      end
      if ($urandom_range(0, 60) == 0) idle_thr = IW'($urandom_range(0, 6));
      if ($urandom_range(0, 80) == 0) force_on = ~force_on;
      rst = ($urandom_range(0, 400) == 0);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
